uart_tx: RTL
============

# uart_tx

Byte-serial UART transmitter downstream of `baud_gen`. Accepts bytes over a valid/ready handshake into a small FIFO and shifts them out LSB-first as 8N1 (optionally 8E1/8O1) frames. Bit timing comes from `baud_gen`'s single-cycle `baud_clk` tick. It carries coincidence-count bytes to the host link.

## Interface
- `DATA_BITS`, 8: bits per character, 5–8.
- `FIFO_DEPTH`, 4: byte FIFO entries, power of two, ≥2.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Only used when `UART_TX_PARITY_EN` is defined.
- `clk` in 1: system clock, 100 MHz. One clock domain only.
- `rst` in 1: reset, synchronous and active-high.
- `baud_tick` in 1: one-`clk` pulse per bit period, from `baud_gen.baud_clk`.
- `in_data` in DATA_BITS: byte to send.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: FIFO can accept a byte.
- `tx` out 1: serial line, idles high, registered.
- `busy` out 1: a frame is in progress.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of bytes held in the FIFO.

## Operation
- Push occurs when `in_valid && in_ready` on a `clk` edge. `in_ready = (fifo_count != FIFO_DEPTH)`, decoded combinationally from the count.
- When the FIFO is full, a push is refused even if a pop happens in the same cycle. `in_valid` is ignored while `in_ready` is low.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP. It advances only on cycles where `baud_tick` is high.
  - IDLE: on a tick with the FIFO non-empty, pop into the shift register, drive `tx`=0, and go to START.
  - START: on a tick, drive `tx`=bit0 and go to DATA with bit index 0.
  - DATA: on each tick, shift right and drive the next bit. After bit DATA_BITS-1 has lasted one tick, go to PARITY (macro defined) or STOP, driving the parity bit or `tx`=1 respectively.
  - PARITY: on a tick, drive `tx`=1 and go to STOP.
  - STOP: stays for STOP_BITS ticks. On the final tick:
    - FIFO non-empty: pop, drive `tx`=0, go to START, with no idle gap.
    - FIFO empty: go to IDLE with `tx`=1.
- Parity bit is XOR of the data bits, then XOR with PARITY_ODD.
- `busy` is high in every state except IDLE.
- Push and pop in the same cycle leave `fifo_count` unchanged.
- FIFO read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `in_ready`=1, `fifo_count`=0.
  - FSM in IDLE; pointers, bit counter and shift register cleared.
- Reset during a frame truncates it: `tx`=1 on the cycle after `rst` is sampled high, and FIFO contents are discarded.
- `tx` changes only on the `clk` edge where `baud_tick`=1 is sampled. Every bit lasts exactly one tick period.
- Latency: a byte pushed into an empty FIFO while idle gets its start bit at the first tick sampled after the push cycle. A tick coincident with the push does not start it.
- Frame length is 1 + DATA_BITS + P + STOP_BITS ticks, where P = 1 if the macro is defined, else 0.
- Pop happens on the tick edge that drives the start bit. `fifo_count` decrements on that same edge.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state and one parity bit are inserted after the data bits. The polarity is set by PARITY_ODD.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic. DATA goes directly to STOP, and PARITY_ODD has no effect.

## Structure
- Package `uart_pkg`:
  - FSM state type `uart_tx_state_t` (IDLE/START/DATA/PARITY/STOP).
  - Line-level constants `UART_IDLE_LVL`=1 and `UART_START_LVL`=0.
- Sub-module `uart_tx_fifo`: synchronous FIFO with push/pop, count and full/empty flags. Same `clk`/`rst`.

## Test plan
- **Idle:** ticks every 10 clk and no push → `tx` stays 1, `busy`=0 for 1000 clk.
- **Single byte:** push 0x55, ticks every 10 clk → `tx` per tick = 0,1,0,1,0,1,0,1,0,1. `busy` falls after the 10th tick, and `fifo_count` returns to 0.
- **Back-to-back:** push 0x01,0x02,0x03,0x04 in four consecutive cycles before the first tick → `fifo_count`=4 and `in_ready`=0, so a 5th `in_valid` stalls. The four frames go out contiguously with no idle bit between stop and start.
- **Parity (macro on, PARITY_ODD=0):** push 0x07 → parity bit 1. With PARITY_ODD=1 → parity bit 0. Frame is 11 ticks.
- **STOP_BITS=2:** push 0xFF → 12 ticks with parity macro on, 11 with it off. The last two bits are 1.
- **Mid-frame reset:** assert `rst` for 1 cycle after the 4th bit of 0xA5 with 2 bytes queued → `tx`=1, `busy`=0, `fifo_count`=0 the next cycle, and no further frames are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmitter.
package uart_pkg;

    // Transmit FSM states; PARITY is only reachable when UART_TX_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    // Parity over a zero-extended character: XOR of all bits, inverted for odd parity
    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
// A push into a full FIFO is refused even when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c    = (count == CNT_W'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_push   = push && !full_c;
    assign do_pop    = pop && !empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO plus a baud-tick driven serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert one parity bit (polarity from PARITY_ODD).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    // Reject parameter sets the datapath widths cannot represent
    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD > 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx: unsupported parameter set");
    end

    uart_tx_state_t         state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   tx_d;
    logic                   busy_d;
    logic                   pop_c;
    logic                   fifo_full_c;
    logic                   fifo_empty_c;
    logic [DATA_BITS-1:0]   fifo_data_c;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .wr_data   (in_data),
        .pop       (pop_c),
        .rd_data_c (fifo_data_c),
        .count     (fifo_count),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    assign in_ready = !fifo_full_c;

    // State, datapath and line registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx         <= UART_IDLE_LVL;
            busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            tx         <= tx_d;
            busy       <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // Next-state and line-level decode; nothing moves except on a baud tick
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx;
        pop_c      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_data_c;
                        tx_d    = UART_START_LVL;
                        state_d = START;
`ifdef UART_TX_PARITY_EN
                        par_d   = frame_parity(8'(fifo_data_c), 1'(PARITY_ODD));
`endif
                    end
                end
                START: begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        tx_d       = par_q;
                        state_d    = PARITY;
`else
                        tx_d       = UART_IDLE_LVL;
                        state_d    = STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_d       = UART_IDLE_LVL;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
`endif
                STOP: begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when a byte is waiting
                        if (!fifo_empty_c) begin
                            pop_c   = 1'b1;
                            shift_d = fifo_data_c;
                            tx_d    = UART_START_LVL;
                            state_d = START;
`ifdef UART_TX_PARITY_EN
                            par_d   = frame_parity(8'(fifo_data_c), 1'(PARITY_ODD));
`endif
                        end else begin
                            tx_d    = UART_IDLE_LVL;
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_d    = UART_IDLE_LVL;
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule
